blockmem_2p_arb: RTL

BLOCKMEM_2P_ARB -- requirements
Module: blockmem_2p_arb

---
 rtl/blockmem_2p_arb.sv | 134 +++++++++++++
 1 files changed

// File: rtl/blockmem_2p_arb.sv
// Two-requester arbiter in front of a simple dual-port block memory (write port A, read port B).
// Optional read-after-write stall: define BLOCKMEM_ARB_RAW_STALL_EN.
module blockmem_2p_arb #(
    parameter int G_DATAWIDTH = 32,
    parameter int G_MEMDEPTH  = 1024,
    parameter int G_BUFFER    = 1,
    parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [1:0]               wr_valid,
    output logic [1:0]               wr_ready,
    input  logic [2*G_ADDRWIDTH-1:0] wr_addr,
    input  logic [2*G_DATAWIDTH-1:0] wr_data,
    input  logic [1:0]               rd_valid,
    output logic [1:0]               rd_ready,
    input  logic [2*G_ADDRWIDTH-1:0] rd_addr,
    output logic [1:0]               rsp_valid,
    output logic [G_DATAWIDTH-1:0]   rsp_data,
    output logic                     mem_ena,
    output logic                     mem_wea,
    output logic [G_ADDRWIDTH-1:0]   mem_addra,
    output logic [G_DATAWIDTH-1:0]   mem_dina,
    output logic                     mem_enb,
    output logic [G_ADDRWIDTH-1:0]   mem_addrb,
    input  logic [G_DATAWIDTH-1:0]   mem_doutb
);

    // Read data leaves the memory G_BUFFER+2 cycles after the read handshake.
    localparam int DEPTH = G_BUFFER + 2;

    // 'last' holds the requester granted most recently; the other one wins a tie.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic last);
        logic [1:0] g;
        if (req == 2'b11)
            g = last ? 2'b01 : 2'b10;
        else
            g = req;
        return g;
    endfunction

    logic                   wr_last;
    logic                   rd_last;
    logic [1:0]             wr_gnt;
    logic [1:0]             rd_gnt;
    logic [1:0]             rd_req;
    logic                   wr_hs;
    logic                   rd_hs;
    logic                   wr_sel;
    logic                   rd_sel;
    logic [G_ADDRWIDTH-1:0] wr_addr_sel;
    logic [G_DATAWIDTH-1:0] wr_data_sel;
    logic [G_ADDRWIDTH-1:0] rd_addr0;
    logic [G_ADDRWIDTH-1:0] rd_addr1;
    logic [G_ADDRWIDTH-1:0] rd_addr_sel;
    logic [DEPTH-1:0]       id_vld_p;
    logic [DEPTH-1:0]       id_p;
    logic [G_DATAWIDTH-1:0] rsp_hold;

    assign rd_addr0 = rd_addr[G_ADDRWIDTH-1:0];
    assign rd_addr1 = rd_addr[2*G_ADDRWIDTH-1:G_ADDRWIDTH];

    assign wr_gnt      = rr_grant(wr_valid, wr_last);
    assign wr_ready    = resetn ? wr_gnt : 2'b00;
    assign wr_hs       = |wr_ready;
    assign wr_sel      = wr_gnt[1];
    assign wr_addr_sel = wr_sel ? wr_addr[2*G_ADDRWIDTH-1:G_ADDRWIDTH] : wr_addr[G_ADDRWIDTH-1:0];
    assign wr_data_sel = wr_sel ? wr_data[2*G_DATAWIDTH-1:G_DATAWIDTH] : wr_data[G_DATAWIDTH-1:0];

`ifdef BLOCKMEM_ARB_RAW_STALL_EN
    // A read colliding with a write not yet committed to the array is held off.
    logic [1:0] raw_hit;
    always_comb begin
        raw_hit    = 2'b00;
        raw_hit[0] = (wr_hs && (rd_addr0 == wr_addr_sel)) || (mem_ena && (rd_addr0 == mem_addra));
        raw_hit[1] = (wr_hs && (rd_addr1 == wr_addr_sel)) || (mem_ena && (rd_addr1 == mem_addra));
    end
    assign rd_req = rd_valid & ~raw_hit;
`else
    assign rd_req = rd_valid;
`endif

    assign rd_gnt      = rr_grant(rd_req, rd_last);
    assign rd_ready    = resetn ? rd_gnt : 2'b00;
    assign rd_hs       = |rd_ready;
    assign rd_sel      = rd_gnt[1];
    assign rd_addr_sel = rd_sel ? rd_addr1 : rd_addr0;

    // ---- stage p0: arbitration result registered onto the memory ports ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_last   <= 1'b1;
            rd_last   <= 1'b1;
            mem_ena   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
            mem_enb   <= 1'b0;
            mem_addrb <= '0;
        end else begin
            mem_ena <= wr_hs;
            mem_enb <= rd_hs;
            if (wr_hs) begin
                wr_last   <= wr_sel;
                mem_addra <= wr_addr_sel;
                mem_dina  <= wr_data_sel;
            end
            if (rd_hs) begin
                rd_last   <= rd_sel;
                mem_addrb <= rd_addr_sel;
            end
        end
    end

    assign mem_wea = mem_ena;

    // ---- stages p0..p(DEPTH-1): requester-ID pipeline tracking reads in flight ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_vld_p <= '0;
            id_p     <= '0;
            rsp_hold <= '0;
        end else begin
            id_vld_p <= {id_vld_p[DEPTH-2:0], rd_hs};
            id_p     <= {id_p[DEPTH-2:0], rd_sel};
            if (id_vld_p[DEPTH-1])
                rsp_hold <= mem_doutb;
        end
    end

    // ---- response: memory data passes straight through while valid, held otherwise ----
    assign rsp_valid = id_vld_p[DEPTH-1] ? (id_p[DEPTH-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = id_vld_p[DEPTH-1] ? mem_doutb : rsp_hold;

endmodule
